refraction_dir_pipe: RTL and testbench

- Parametrised successor to the single-mode refraction-direction unit.
- Computes either the refracted or the reflected direction of an incident vector about a unit normal, in signed fixed point.
- Sits between the hit-shading stage and secondary-ray generation.
- Uses an iterative square root, a ready/valid output hold and explicit total-internal-reflection (TIR) reporting.

---
 rtl/refraction_dir_pipe_pkg.sv | 45 ++++
 rtl/refraction_dir_pipe_sqrt.sv | 64 ++++++
 rtl/refraction_dir_pipe.sv | 184 ++++++++++++++++++
 tb/tb_refraction_dir_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/refraction_dir_pipe_pkg.sv
// Shared fixed-point math for the refraction/reflection direction pipeline.
// Holds default sizes, the unit constant, the vector and FSM types, and the
// saturate / fixed-multiply helpers. Helpers work on 64-bit containers, so
// component widths up to 32 bits are supported.
package refraction_dir_pipe_pkg;

   localparam int unsigned FRAC_BITS_DEF = 14;
   localparam int unsigned WIDTH_DEF     = 32;
   localparam int          ONE           = 1 << FRAC_BITS_DEF;

   // Three packed components, dim0 in the low bits.
   typedef logic [2:0][WIDTH_DEF-1:0] vec3_t;

   typedef enum logic [2:0] {
      StIdle,
      StDot,
      StK1,
      StK2,
      StSqrt,
      StCombine,
      StDone
   } state_e;

   // Clamp a signed value to the range of a w-bit signed number.
   function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v,
                                                 input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Fixed-point multiply: full product, arithmetic shift, truncation (floor).
   function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned frac);
      logic signed [63:0] p;
      p = a * b;
      return p >>> frac;
   endfunction

endpackage

// File: rtl/refraction_dir_pipe_sqrt.sv
// fixed_sqrt_iter: restoring integer square root, one result bit per clock.
// With radicand = k << FRAC_BITS the root is floor(sqrt(k)) in Q(FRAC_BITS).
// done is high during the last iteration cycle, so root is valid on the
// clock after done.
module fixed_sqrt_iter
   import refraction_dir_pipe_pkg::*;
#(
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [2*FRAC_BITS+1:0] radicand,
   output logic                   busy,
   output logic                   done,
   output logic [FRAC_BITS:0]     root
);

   localparam int unsigned ITER = FRAC_BITS + 1;
   localparam int unsigned CW   = $clog2(ITER + 1);
   localparam int unsigned RW   = FRAC_BITS + 5;

   logic [2*FRAC_BITS+1:0] rad_q;
   logic [RW-1:0]          rem_q;
   logic [FRAC_BITS:0]     root_q;
   logic [CW-1:0]          cnt_q;
   logic [RW-1:0]          rem_sh;
   logic [RW-1:0]          trial;
   logic [RW-1:0]          rem_n;
   logic                   ge;

   // One restoring step: bring down the next bit pair and try subtracting 4*root+1.
   always_comb begin
      rem_sh = (rem_q << 2) | {{(RW - 2){1'b0}}, rad_q[2*FRAC_BITS+1 -: 2]};
      trial  = {2'b00, root_q, 2'b01};
      ge     = (rem_sh >= trial);
      rem_n  = ge ? (rem_sh - trial) : rem_sh;
   end

   // Iteration state; start reloads and restarts unconditionally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else if (start) begin
         rad_q  <= radicand;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= CW'(ITER);
      end else if (cnt_q != '0) begin
         rad_q  <= rad_q << 2;
         rem_q  <= rem_n;
         root_q <= {root_q[FRAC_BITS-1:0], ge};
         cnt_q  <= cnt_q - CW'(1);
      end
   end

   assign busy = (cnt_q != '0);
   assign done = (cnt_q == CW'(1));
   assign root = root_q;

endmodule

// File: rtl/refraction_dir_pipe.sv
// refraction_dir_pipe: refracted (mode=0) or reflected (mode=1) direction of
// an incident vector about a unit normal, in signed Q(FRAC_BITS) fixed point.
// Each product is saturated to WIDTH, sums run at WIDTH+2 and are saturated.
// Optional feature macro REFRACTION_TIR_REFLECT_EN: when defined, a total
// internal reflection case outputs the reflection direction instead of zero.
module refraction_dir_pipe
   import refraction_dir_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               strobe,
   output logic               ready,
   input  logic               mode,
   input  logic [3*WIDTH-1:0] n,
   input  logic [3*WIDTH-1:0] i,
   input  logic [WIDTH-1:0]   eta,
   output logic [3*WIDTH-1:0] r,
   output logic               tir,
   output logic               valid,
   input  logic               out_ready
);

   localparam int unsigned SW    = WIDTH + 2;
   localparam int unsigned RAD_W = 2*FRAC_BITS + 2;
   localparam logic signed [SW-1:0] ONE_S = SW'(64'sd1 <<< FRAC_BITS);
   // Largest k whose shifted value still fits the square-root radicand.
   localparam logic signed [SW-1:0] K_MAX = SW'((64'sd1 <<< (FRAC_BITS + 2)) - 64'sd1);

   function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [SW-1:0] v);
      return WIDTH'(sat_fn(64'(v), WIDTH));
   endfunction

   function automatic logic signed [WIDTH-1:0] mul_w(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
      return WIDTH'(sat_fn(fx_mul(64'(a), 64'(b), FRAC_BITS), WIDTH));
   endfunction

   // eta is an unsigned magnitude, so it is zero-extended before the multiply.
   function automatic logic signed [WIDTH-1:0] mul_eta(input logic [WIDTH-1:0] e,
                                                       input logic signed [WIDTH-1:0] b);
      return WIDTH'(sat_fn(fx_mul(64'(e), 64'(b), FRAC_BITS), WIDTH));
   endfunction

   function automatic logic signed [SW-1:0] ext(input logic signed [WIDTH-1:0] v);
      return SW'(v);
   endfunction

   state_e state_q, state_d;

   logic                    mode_q;
   logic [WIDTH-1:0]        eta_q;
   logic signed [WIDTH-1:0] n_q [3];
   logic signed [WIDTH-1:0] i_q [3];
   logic signed [WIDTH-1:0] cosi_q, cosi2_q, eta2_q;
   logic                    tirp_q;
   logic signed [WIDTH-1:0] r_q [3];
   logic                    tir_q;

   logic                    accept;
   logic signed [SW-1:0]    dot, om, kk, k_lim, root_s;
   logic signed [WIDTH-1:0] cosi_d, c_coef;
   logic signed [WIDTH-1:0] m_cn [3];
   logic signed [WIDTH-1:0] refl [3];
   logic signed [WIDTH-1:0] refr [3];
   logic signed [WIDTH-1:0] res  [3];
   logic                    k_neg;
   logic [RAD_W-1:0]        radicand;
   logic                    sqrt_start, sqrt_busy, sqrt_done;
   logic [FRAC_BITS:0]      sqrt_root;

   assign ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept = strobe && ready;
   assign valid  = (state_q == StDone);
   assign tir    = tir_q;
   assign r      = {r_q[2], r_q[1], r_q[0]};

   fixed_sqrt_iter #(
      .FRAC_BITS (FRAC_BITS)
   ) u_sqrt (
      .clk      (clk),
      .resetn   (resetn),
      .start    (sqrt_start),
      .radicand (radicand),
      .busy     (sqrt_busy),
      .done     (sqrt_done),
      .root     (sqrt_root)
   );

   // Datapath: cosi, k / TIR test, and both candidate result vectors.
   always_comb begin
      dot = '0;
      for (int d = 0; d < 3; d++) dot = dot + ext(mul_w(n_q[d], i_q[d]));
      cosi_d   = sat_w(-dot);
      om       = ONE_S - ext(cosi2_q);
      kk       = ONE_S - ext(mul_w(eta2_q, sat_w(om)));
      k_neg    = kk[SW-1];
      k_lim    = (kk > K_MAX) ? K_MAX : kk;
      radicand = RAD_W'(k_lim) << FRAC_BITS;
      root_s   = SW'(sqrt_root);
      c_coef   = sat_w(ext(mul_eta(eta_q, cosi_q)) - root_s);
      for (int d = 0; d < 3; d++) begin
         m_cn[d] = mul_w(cosi_q, n_q[d]);
         refl[d] = sat_w(ext(i_q[d]) + ext(m_cn[d]) + ext(m_cn[d]));
         refr[d] = sat_w(ext(mul_eta(eta_q, i_q[d])) + ext(mul_w(c_coef, n_q[d])));
         if (mode_q) begin
            res[d] = refl[d];
         end else if (tirp_q) begin
`ifdef REFRACTION_TIR_REFLECT_EN
            res[d] = refl[d];
`else
            res[d] = '0;
`endif
         end else begin
            res[d] = refr[d];
         end
      end
   end

   // Next-state decode; the square root is launched on the K2 -> SQRT edge.
   always_comb begin
      state_d    = state_q;
      sqrt_start = 1'b0;
      unique case (state_q)
         StIdle:    if (accept) state_d = StDot;
         StDot:     state_d = mode_q ? StCombine : StK1;
         StK1:      state_d = StK2;
         StK2: begin
            if (k_neg) begin
               state_d = StCombine;
            end else begin
               state_d    = StSqrt;
               sqrt_start = 1'b1;
            end
         end
         StSqrt:    if (sqrt_done || !sqrt_busy) state_d = StCombine;
         StCombine: state_d = StDone;
         StDone:    if (out_ready) state_d = strobe ? StDot : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State, captured operands, per-stage intermediates and the held result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         eta_q   <= '0;
         cosi_q  <= '0;
         cosi2_q <= '0;
         eta2_q  <= '0;
         tirp_q  <= 1'b0;
         tir_q   <= 1'b0;
         for (int d = 0; d < 3; d++) begin
            n_q[d] <= '0;
            i_q[d] <= '0;
            r_q[d] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            mode_q <= mode;
            eta_q  <= eta;
            for (int d = 0; d < 3; d++) begin
               n_q[d] <= n[d*WIDTH +: WIDTH];
               i_q[d] <= i[d*WIDTH +: WIDTH];
            end
         end
         if (state_q == StDot) cosi_q <= cosi_d;
         if (state_q == StK1) begin
            cosi2_q <= mul_w(cosi_q, cosi_q);
            eta2_q  <= WIDTH'(sat_fn(fx_mul(64'(eta_q), 64'(eta_q), FRAC_BITS), WIDTH));
         end
         if (state_q == StK2) tirp_q <= k_neg;
         if (state_q == StCombine) begin
            for (int d = 0; d < 3; d++) r_q[d] <= res[d];
            tir_q <= mode_q ? 1'b0 : tirp_q;
         end
      end
   end

endmodule

// File: tb/tb_refraction_dir_pipe.sv
// Directed bench for refraction_dir_pipe with a scoreboard queue of expected
// results. Expected TIR output depends on REFRACTION_TIR_REFLECT_EN.
module tb_refraction_dir_pipe;
   import refraction_dir_pipe_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         strobe = 1'b0;
   logic         mode = 1'b0;
   logic         out_ready = 1'b0;
   vec3_t        n = '0;
   vec3_t        i = '0;
   logic [W-1:0] eta = '0;
   logic [3*W-1:0] r;
   logic         ready, tir, valid;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [3*W-1:0] r;
      logic           tir;
      int             lat;
      int             tol;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   refraction_dir_pipe #(
      .WIDTH     (W),
      .FRAC_BITS (FRAC_BITS_DEF)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .strobe    (strobe),
      .ready     (ready),
      .mode      (mode),
      .n         (n),
      .i         (i),
      .eta       (eta),
      .r         (r),
      .tir       (tir),
      .valid     (valid),
      .out_ready (out_ready)
   );

   function automatic vec3_t mk(input int x, input int y, input int z);
      vec3_t v;
      v[0] = x;
      v[1] = y;
      v[2] = z;
      return v;
   endfunction

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_vec(input string tag, input logic [3*W-1:0] got,
                            input logic [3*W-1:0] exp, input int tol);
      logic ok;
      int   g, e;
      ok = 1'b1;
      for (int d = 0; d < 3; d++) begin
         g = $signed(got[d*W +: W]);
         e = $signed(exp[d*W +: W]);
         if (^got[d*W +: W] === 1'bx) ok = 1'b0;
         else if (g - e > tol || e - g > tol) ok = 1'b0;
      end
      n_checks++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Present one request (optionally with out_ready for a back-to-back accept).
   task automatic start_op(input string tag, input logic m, input vec3_t nv, input vec3_t iv,
                           input logic [W-1:0] e, input vec3_t er, input logic et,
                           input int lat, input int tol, input logic rdy_out);
      exp_t x;
      @(negedge clk);
      mode = m;
      n = nv;
      i = iv;
      eta = e;
      out_ready = rdy_out;
      strobe = 1'b1;
      #1;
      check_bit({tag, "_ready"}, ready, 1'b1);
      x.r = er;
      x.tir = et;
      x.lat = lat;
      x.tol = tol;
      sb.push_back(x);
      @(posedge clk);
      #1;
      strobe = 1'b0;
      out_ready = 1'b0;
      mode = ~m;
      n = {$urandom, $urandom, $urandom};
      i = {$urandom, $urandom, $urandom};
      eta = $urandom;
   endtask

   // Wait (bounded) for valid, then compare against the scoreboard head.
   task automatic wait_result(input string tag);
      int   cyc;
      logic seen;
      exp_t x;
      cyc = 0;
      seen = 1'b0;
      while (cyc < 60 && !seen) begin
         if (valid === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      check_bit({tag, "_valid_seen"}, seen, 1'b1);
      if (sb.size() == 0) begin
         check_int({tag, "_sb_empty"}, 0, 1);
      end else begin
         x = sb.pop_front();
         check_int({tag, "_latency"}, cyc, x.lat);
         check_vec({tag, "_r"}, r, x.r, x.tol);
         check_bit({tag, "_tir"}, tir, x.tir);
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_bit({tag, "_valid_drop"}, valid, 1'b0);
      check_bit({tag, "_ready_idle"}, ready, 1'b1);
   endtask

   vec3_t nrm, i_axis, i_obl, r_axis, r_refl, r_tir;

   initial begin
      nrm    = mk(0, ONE, 0);
      i_axis = mk(0, -ONE, 0);
      i_obl  = mk(11585, -11585, 0);
      r_axis = mk(0, -ONE, 0);
      r_refl = mk(11585, 11585, 0);
`ifdef REFRACTION_TIR_REFLECT_EN
      r_tir  = mk(11585, 11585, 0);
`else
      r_tir  = mk(0, 0, 0);
`endif

      #2;
      check_bit("reset_ready", ready, 1'b1);
      check_bit("reset_valid", valid, 1'b0);
      check_bit("reset_tir", tir, 1'b0);
      check_vec("reset_r", r, '0, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      start_op("reflect", 1'b1, nrm, i_obl, W'(ONE), r_refl, 1'b0, 2, 0, 1'b0);
      wait_result("reflect");
      release_out("reflect");

      start_op("identity", 1'b0, nrm, i_axis, W'(ONE), r_axis, 1'b0, 19, 0, 1'b0);
      wait_result("identity");
      release_out("identity");

      start_op("normal_inc", 1'b0, nrm, i_axis, W'(10923), r_axis, 1'b0, 19, 1, 1'b0);
      wait_result("normal_inc");
      release_out("normal_inc");

      // eta=1 at 45 degrees passes the ray straight through (within 1 LSB).
      start_op("oblique_eta1", 1'b0, nrm, i_obl, W'(ONE), i_obl, 1'b0, 19, 1, 1'b0);
      wait_result("oblique_eta1");
      release_out("oblique_eta1");

      start_op("tir", 1'b0, nrm, i_obl, W'(32768), r_tir, 1'b1, 4, 0, 1'b0);
      wait_result("tir");
      release_out("tir");

      // Same TIR-inducing operands in reflect mode: tir must stay low.
      start_op("reflect_big_eta", 1'b1, nrm, i_obl, W'(32768), r_refl, 1'b0, 2, 0, 1'b0);
      wait_result("reflect_big_eta");
      release_out("reflect_big_eta");

      // Hold the result for 10 cycles while junk requests are presented.
      start_op("hold", 1'b1, nrm, i_obl, W'(ONE), r_refl, 1'b0, 2, 0, 1'b0);
      wait_result("hold");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         strobe = 1'b1;
         mode = 1'b0;
         #1;
         check_bit("hold_ready_low", ready, 1'b0);
         @(posedge clk);
         #1;
         check_bit("hold_valid", valid, 1'b1);
         check_vec("hold_r", r, r_refl, 0);
         check_bit("hold_tir", tir, 1'b0);
      end
      strobe = 1'b0;

      // Result consumed and a new request accepted on the same edge.
      start_op("b2b", 1'b0, nrm, i_axis, W'(ONE), r_axis, 1'b0, 19, 0, 1'b1);
      check_bit("b2b_valid_drop", valid, 1'b0);
      check_bit("b2b_busy", ready, 1'b0);
      wait_result("b2b");
      release_out("b2b");

      // Abort during the square-root phase.
      start_op("abort", 1'b0, nrm, i_obl, W'(ONE), i_obl, 1'b0, 19, 1, 1'b0);
      repeat (8) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check_bit("abort_valid", valid, 1'b0);
      check_bit("abort_ready", ready, 1'b1);
      check_bit("abort_tir", tir, 1'b0);
      check_vec("abort_r", r, '0, 0);
      if (sb.size() > 0) sb.delete();
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_bit("abort_no_result", valid, 1'b0);

      start_op("after_abort", 1'b0, nrm, i_axis, W'(10923), r_axis, 1'b0, 19, 1, 1'b0);
      wait_result("after_abort");
      release_out("after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
